// File: rtl/obi_to_axi_bridge_if.sv
// AXI4 bus bundle (AXI_BUS) with Master/Slave modports, carrying one full
// AW/W/B/AR/R channel set.
// Handshake rule on every channel: a beat transfers on a rising clk edge
// where valid and ready are both 1. Once raised, valid and its payload stay
// stable until that edge.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/obi_to_axi_bridge.sv
// OBI (cv32e40p instr/data port) to single-beat AXI4 master bridge.
// One transaction in flight; all AXI valids/readies and the OBI response are
// registered, so there is no combinational OBI->AXI valid path.
// Optional feature: define OBI_TO_AXI_ERR_EN to report SLVERR/DECERR on
// obi_err_o; without it obi_err_o is tied 0 and no response code is stored.
// Handshake rule: an AXI beat transfers on a clk edge where valid and ready
// are both 1; this bridge holds each valid and its payload until that edge.
module obi_to_axi_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 16,
  parameter int unsigned AXI_USER_WIDTH = 10,
  parameter int unsigned AXI_ID         = 0,
  parameter logic [2:0]  AXI_PROT       = 3'b000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        obi_req_i,
  output logic        obi_gnt_o,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  AXI_BUS.Master      AXI_Master
);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_R} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        aw_valid_q;
  logic        w_valid_q;
  logic        ar_valid_q;
  logic        b_ready_q;
  logic        r_ready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        aw_hs;
  logic        w_hs;

  // Grant only while idle; the previous response cycle is already IDLE.
  assign obi_gnt_o = obi_req_i && (state_q == IDLE);
  assign aw_hs     = aw_valid_q && AXI_Master.aw_ready;
  assign w_hs      = w_valid_q && AXI_Master.w_ready;

  // AW channel: captured address, fixed single-beat INCR attributes.
  assign AXI_Master.aw_id     = AXI_ID_WIDTH'(AXI_ID);
  assign AXI_Master.aw_addr   = AXI_ADDR_WIDTH'(addr_q);
  assign AXI_Master.aw_len    = 8'd0;
  assign AXI_Master.aw_size   = 3'b010;
  assign AXI_Master.aw_burst  = 2'b01;
  assign AXI_Master.aw_lock   = 1'b0;
  assign AXI_Master.aw_cache  = 4'b0000;
  assign AXI_Master.aw_prot   = AXI_PROT;
  assign AXI_Master.aw_qos    = 4'd0;
  assign AXI_Master.aw_region = 4'd0;
  assign AXI_Master.aw_atop   = 6'd0;
  assign AXI_Master.aw_user   = '0;
  assign AXI_Master.aw_valid  = aw_valid_q;

  assign AXI_Master.w_data    = wdata_q;
  assign AXI_Master.w_strb    = be_q;
  assign AXI_Master.w_last    = 1'b1;
  assign AXI_Master.w_user    = '0;
  assign AXI_Master.w_valid   = w_valid_q;

  assign AXI_Master.b_ready   = b_ready_q;

  assign AXI_Master.ar_id     = AXI_ID_WIDTH'(AXI_ID);
  assign AXI_Master.ar_addr   = AXI_ADDR_WIDTH'(addr_q);
  assign AXI_Master.ar_len    = 8'd0;
  assign AXI_Master.ar_size   = 3'b010;
  assign AXI_Master.ar_burst  = 2'b01;
  assign AXI_Master.ar_lock   = 1'b0;
  assign AXI_Master.ar_cache  = 4'b0000;
  assign AXI_Master.ar_prot   = AXI_PROT;
  assign AXI_Master.ar_qos    = 4'd0;
  assign AXI_Master.ar_region = 4'd0;
  assign AXI_Master.ar_user   = '0;
  assign AXI_Master.ar_valid  = ar_valid_q;

  assign AXI_Master.r_ready   = r_ready_q;

  assign obi_rvalid_o = rvalid_q;
  assign obi_rdata_o  = rdata_q;

`ifdef OBI_TO_AXI_ERR_EN
  logic err_q;
  assign obi_err_o = err_q;

  // Error flag: resp[1] of the completing B or R beat, held until next response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if ((state_q == WR_B) && AXI_Master.b_valid) begin
      err_q <= AXI_Master.b_resp[1];
    end else if ((state_q == RD_R) && AXI_Master.r_valid) begin
      err_q <= AXI_Master.r_resp[1];
    end
  end
`else
  assign obi_err_o = 1'b0;
`endif

  // Single-beat transfers carry no information in these fields.
  logic unused_axi;
  assign unused_axi = ^{AXI_Master.b_id, AXI_Master.b_user, AXI_Master.b_resp,
                        AXI_Master.r_id, AXI_Master.r_user, AXI_Master.r_resp,
                        AXI_Master.r_last};

  // Request/grant FSM; all AXI handshake signals and the response are registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      b_ready_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (obi_gnt_o) begin
            addr_q  <= obi_addr_i;
            wdata_q <= obi_wdata_i;
            be_q    <= obi_be_i;
            if (obi_we_i) begin
              state_q    <= WR;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              state_q    <= RD_A;
              ar_valid_q <= 1'b1;
            end
          end
        end
        WR: begin
          // AW and W complete independently; a finished channel drops its valid.
          if (aw_hs) aw_valid_q <= 1'b0;
          if (w_hs)  w_valid_q  <= 1'b0;
          if ((aw_hs || !aw_valid_q) && (w_hs || !w_valid_q)) begin
            state_q   <= WR_B;
            b_ready_q <= 1'b1;
          end
        end
        WR_B: begin
          if (AXI_Master.b_valid) begin
            state_q   <= IDLE;
            b_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= '0;
          end
        end
        RD_A: begin
          if (AXI_Master.ar_ready) begin
            state_q    <= RD_R;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
          end
        end
        RD_R: begin
          if (AXI_Master.r_valid) begin
            state_q   <= IDLE;
            r_ready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= AXI_Master.r_data;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_to_axi_bridge.sv
// Directed bench for obi_to_axi_bridge: OBI driver tasks, a negedge-driven
// AXI slave with a word memory and per-channel wait knobs, and a final report.
module tb_obi_to_axi_bridge;

  logic        clk;
  logic        rst_n;
  logic        obi_req;
  logic        obi_gnt;
  logic [31:0] obi_addr;
  logic        obi_we;
  logic [3:0]  obi_be;
  logic [31:0] obi_wdata;
  logic        obi_rvalid;
  logic [31:0] obi_rdata;
  logic        obi_err;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(16),
            .AXI_USER_WIDTH(10)) axi ();

  obi_to_axi_bridge dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .obi_req_i    (obi_req),
    .obi_gnt_o    (obi_gnt),
    .obi_addr_i   (obi_addr),
    .obi_we_i     (obi_we),
    .obi_be_i     (obi_be),
    .obi_wdata_i  (obi_wdata),
    .obi_rvalid_o (obi_rvalid),
    .obi_rdata_o  (obi_rdata),
    .obi_err_o    (obi_err),
    .AXI_Master   (axi)
  );

`ifdef OBI_TO_AXI_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  int exp_rv  = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- AXI slave model ----------------
  logic [31:0] mem [128];
  int aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0, b_wait = 0;
  logic [1:0] rresp_k = 2'b00, bresp_k = 2'b00;
  int aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt;
  logic aw_got, w_got, ar_got, b_fire, r_fire;
  int aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, rv_count = 0;
  int outstanding = 0, max_outstanding = 0, b_early = 0, aw_unstable = 0;
  int aw_vc, w_vc, last_aw_vc = 0, last_w_vc = 0;
  logic [31:0] aw_first;
  logic [31:0] s_aw_addr, s_ar_addr, s_w_data;
  logic [7:0]  s_aw_len, s_ar_len;
  logic [2:0]  s_aw_size, s_ar_size, s_aw_prot;
  logic [1:0]  s_aw_burst, s_ar_burst;
  logic [3:0]  s_w_strb, s_aw_cache;
  logic [15:0] s_aw_id;
  logic        s_w_last;

  task automatic slave_clear();
    axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
    axi.b_valid = 0; axi.b_resp = 0; axi.b_id = 0; axi.b_user = 0;
    axi.r_valid = 0; axi.r_resp = 0; axi.r_id = 0; axi.r_user = 0;
    axi.r_data = 0; axi.r_last = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; b_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
    aw_vc = 0; w_vc = 0; outstanding = 0;
  endtask

  initial begin : slave
    slave_clear();
    forever begin
      @(negedge clk);
      if (obi_rvalid) rv_count++;
      if (!rst_n) begin
        slave_clear();
      end else begin
        if (b_fire) begin
          axi.b_valid = 0; b_fire = 0; aw_got = 0; w_got = 0; b_cnt = 0;
          last_aw_vc = aw_vc; last_w_vc = w_vc; aw_vc = 0; w_vc = 0;
        end
        if (r_fire) begin
          axi.r_valid = 0; axi.r_last = 0; r_fire = 0; ar_got = 0; r_cnt = 0;
          outstanding--;
        end
        if (axi.b_ready && !aw_got) b_early++;
        if (aw_got && w_got && !axi.b_valid) begin
          if (b_cnt >= b_wait) begin
            for (int b = 0; b < 4; b++)
              if (s_w_strb[b]) mem[s_aw_addr[8:2]][8*b +: 8] = s_w_data[8*b +: 8];
            axi.b_valid = 1; axi.b_resp = bresp_k;
          end else b_cnt++;
        end
        if (axi.b_valid && axi.b_ready) b_fire = 1;
        if (ar_got && !axi.r_valid) begin
          if (r_cnt >= r_wait) begin
            axi.r_valid = 1; axi.r_data = mem[s_ar_addr[8:2]];
            axi.r_resp = rresp_k; axi.r_last = 1;
          end else r_cnt++;
        end
        if (axi.r_valid && axi.r_ready) r_fire = 1;
        if (axi.aw_valid) begin
          if (aw_vc == 0) aw_first = axi.aw_addr;
          else if (axi.aw_addr !== aw_first) aw_unstable++;
          aw_vc++;
        end
        if (axi.w_valid) w_vc++;
        if (axi.aw_valid && !aw_got) begin
          if (aw_cnt >= aw_wait) begin
            axi.aw_ready = 1; aw_got = 1; aw_cnt = 0; aw_hs_n++;
            s_aw_addr = axi.aw_addr; s_aw_len = axi.aw_len; s_aw_size = axi.aw_size;
            s_aw_burst = axi.aw_burst; s_aw_id = axi.aw_id; s_aw_cache = axi.aw_cache;
            s_aw_prot = axi.aw_prot;
          end else begin axi.aw_ready = 0; aw_cnt++; end
        end else axi.aw_ready = 0;
        if (axi.w_valid && !w_got) begin
          if (w_cnt >= w_wait) begin
            axi.w_ready = 1; w_got = 1; w_cnt = 0; w_hs_n++;
            s_w_data = axi.w_data; s_w_strb = axi.w_strb; s_w_last = axi.w_last;
          end else begin axi.w_ready = 0; w_cnt++; end
        end else axi.w_ready = 0;
        if (axi.ar_valid && !ar_got) begin
          if (ar_cnt >= ar_wait) begin
            axi.ar_ready = 1; ar_got = 1; ar_cnt = 0; ar_hs_n++;
            s_ar_addr = axi.ar_addr; s_ar_len = axi.ar_len; s_ar_size = axi.ar_size;
            s_ar_burst = axi.ar_burst;
            outstanding++;
            if (outstanding > max_outstanding) max_outstanding = outstanding;
          end else begin axi.ar_ready = 0; ar_cnt++; end
        end else axi.ar_ready = 0;
      end
    end
  end

  // ---------------- OBI driver ----------------
  // One complete request; lat = cycles from the grant cycle to the rvalid cycle.
  task automatic obi_xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
    int n;
    @(negedge clk);
    obi_req = 1; obi_we = we; obi_addr = addr; obi_be = be; obi_wdata = wdata;
    n = 0;
    #1;
    while (!obi_gnt && n < 50) begin @(negedge clk); #1; n++; end
    check_eq("gnt", 32'(obi_gnt), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) obi_req = 0;
      lat++;
      #1;
    end while (!obi_rvalid && lat < 100);
    check_eq("rvalid_seen", 32'(obi_rvalid), 32'd1);
    rdata = obi_rdata; err = obi_err;
    exp_rv++;
  endtask

  task automatic idle_check_rv(input string tag);
    repeat (3) @(negedge clk);
    #1;
    check_eq(tag, 32'(rv_count), 32'(exp_rv));
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] rd;
    logic        err;
    int          lat, grants, resps, cyc, n;
    logic        adv;

    rst_n = 0; obi_req = 0; obi_we = 0; obi_addr = 0; obi_be = 0; obi_wdata = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'hCAFE_0000 | 32'(i * 4);
    mem[7'h41] = 32'h1122_3344;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_gnt", 32'(obi_gnt), 0);
    check_eq("rst_rvalid", 32'(obi_rvalid), 0);
    check_eq("rst_rdata", obi_rdata, 0);
    check_eq("rst_err", 32'(obi_err), 0);
    check_eq("rst_axi_valids", {27'd0, axi.aw_valid, axi.w_valid, axi.ar_valid,
                                axi.b_ready, axi.r_ready}, 0);
    @(negedge clk);
    rst_n = 1;

    // Full-word write then read back, zero-wait slave.
    obi_xfer(1, 32'h100, 4'hF, 32'hDEAD_BEEF, rd, err, lat);
    check_eq("wr_lat", 32'(lat), 3);
    check_eq("wr_rdata", rd, 0);
    check_eq("wr_err", 32'(err), 0);
    check_eq("wr_aw_cnt", 32'(aw_hs_n), 1);
    check_eq("wr_w_cnt", 32'(w_hs_n), 1);
    check_eq("aw_addr", s_aw_addr, 32'h100);
    check_eq("aw_len", 32'(s_aw_len), 0);
    check_eq("aw_size", 32'(s_aw_size), 2);
    check_eq("aw_burst", 32'(s_aw_burst), 1);
    check_eq("aw_id_cache_prot", {9'd0, s_aw_id, s_aw_cache, s_aw_prot}, 0);
    check_eq("w_strb", 32'(s_w_strb), 32'hF);
    check_eq("w_last", 32'(s_w_last), 1);
    obi_xfer(0, 32'h100, 4'hF, 32'h0, rd, err, lat);
    check_eq("rd_data", rd, 32'hDEAD_BEEF);
    check_eq("rd_err", 32'(err), 0);
    check_eq("rd_lat", 32'(lat), 3);
    check_eq("ar_len_size_burst", {19'd0, s_ar_len, s_ar_size, s_ar_burst}, {19'd0, 8'd0, 3'd2, 2'd1});
    idle_check_rv("rv_count_basic");
    check_eq("rdata_hold", obi_rdata, 32'hDEAD_BEEF);

    // Byte-lane write.
    obi_xfer(1, 32'h104, 4'b0010, 32'h0000_AB00, rd, err, lat);
    obi_xfer(0, 32'h104, 4'hF, 32'h0, rd, err, lat);
    check_eq("byte_wr_readback", rd, 32'h1122_AB44);

    // AW held off 5 cycles while W is accepted at once.
    aw_wait = 5;
    obi_xfer(1, 32'h108, 4'hF, 32'h1234_5678, rd, err, lat);
    aw_wait = 0;
    check_eq("skew_lat", 32'(lat), 8);
    check_eq("skew_w_valid_cycles", 32'(last_w_vc), 1);
    check_eq("skew_aw_valid_cycles", 32'(last_aw_vc), 6);
    check_eq("skew_aw_addr_stable", 32'(aw_unstable), 0);
    check_eq("skew_b_ready_early", 32'(b_early), 0);
    check_eq("skew_mem", mem[7'h42], 32'h1234_5678);
    idle_check_rv("rv_count_skew");

    // Back-to-back reads with req held high, R delayed 2 cycles.
    r_wait = 2;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hCAFE_0000 | 32'(i * 4));
    grants = 0; resps = 0; cyc = 0; adv = 0;
    @(negedge clk);
    obi_req = 1; obi_we = 0; obi_be = 4'hF; obi_addr = 32'h0;
    while (resps < 4 && cyc < 200) begin
      #1;
      if (obi_rvalid) begin
        check_eq("b2b_rdata", obi_rdata, exp_q.pop_front());
        resps++;
      end
      if (obi_gnt) begin
        if (grants > 0) check_eq("b2b_gnt_with_rvalid", 32'(obi_rvalid), 1);
        grants++;
        adv = 1;
      end
      @(negedge clk);
      cyc++;
      if (adv) begin
        adv = 0;
        if (grants < 4) obi_addr = 32'(grants * 4);
        else obi_req = 0;
      end
    end
    exp_rv += 4;
    check_eq("b2b_grants", 32'(grants), 4);
    check_eq("b2b_resps", 32'(resps), 4);
    check_eq("b2b_max_outstanding", 32'(max_outstanding), 1);
    idle_check_rv("rv_count_b2b");
    r_wait = 0;

    // Write with no byte enables: issued normally, memory untouched.
    obi_xfer(1, 32'h10C, 4'b0000, 32'hFFFF_FFFF, rd, err, lat);
    check_eq("be0_strb", 32'(s_w_strb), 0);
    check_eq("be0_err", 32'(err), 0);
    obi_xfer(0, 32'h10C, 4'hF, 32'h0, rd, err, lat);
    check_eq("be0_readback", rd, 32'hCAFE_010C);

    // Error responses.
    rresp_k = 2'b10;
    obi_xfer(0, 32'h0, 4'hF, 32'h0, rd, err, lat);
    rresp_k = 2'b00;
    check_eq("rd_slverr_err", 32'(err), 32'(EXP_ERR));
    check_eq("rd_slverr_data", rd, 32'hCAFE_0000);
    bresp_k = 2'b11;
    obi_xfer(1, 32'h110, 4'hF, 32'h0BAD_F00D, rd, err, lat);
    bresp_k = 2'b00;
    check_eq("wr_decerr_err", 32'(err), 32'(EXP_ERR));
    check_eq("wr_decerr_rdata", rd, 0);
    obi_xfer(0, 32'h110, 4'hF, 32'h0, rd, err, lat);
    check_eq("after_err_ok", 32'(err), 0);
    check_eq("after_err_data", rd, 32'h0BAD_F00D);

    // Reset while waiting for R.
    r_wait = 6;
    @(negedge clk);
    obi_req = 1; obi_we = 0; obi_addr = 32'h4; obi_be = 4'hF;
    #1;
    check_eq("mid_rst_gnt", 32'(obi_gnt), 1);
    @(negedge clk);
    obi_req = 0;
    n = 0;
    #1;
    while (!axi.r_ready && n < 20) begin @(negedge clk); #1; n++; end
    check_eq("mid_rst_in_rd_r", 32'(axi.r_ready), 1);
    rst_n = 0;
    #1;
    check_eq("mid_rst_r_ready", 32'(axi.r_ready), 0);
    check_eq("mid_rst_ar_valid", 32'(axi.ar_valid), 0);
    check_eq("mid_rst_rvalid", 32'(obi_rvalid), 0);
    check_eq("mid_rst_rdata", obi_rdata, 0);
    check_eq("mid_rst_err", 32'(obi_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    r_wait = 0;
    repeat (10) @(negedge clk);
    #1;
    check_eq("mid_rst_no_rvalid", 32'(rv_count), 32'(exp_rv));
    obi_xfer(0, 32'h104, 4'hF, 32'h0, rd, err, lat);
    check_eq("post_rst_data", rd, 32'h1122_AB44);
    check_eq("post_rst_lat", 32'(lat), 3);
    idle_check_rv("rv_count_final");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
